// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by both the transmit and receive sides.
//   - uart_state_t   : frame sequencer states
//   - OVERSAMPLE_DEF : default number of baud ticks per bit period
//   - MAX_DATA_BITS  : widest data field any UART block supports
//   - parity_f()     : parity of a (zero-extended) data word, even or odd
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int MAX_DATA_BITS  = 9;

    // Zero-extending narrower words into this argument does not change the
    // XOR reduction, so one function serves every DATA_BITS setting.
    function automatic logic parity_f(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmit sequencer driven by a shared oversampling baud tick.
//   Takes one word per handshake and serialises it as
//   start / data (LSB first) / [parity] / stop on o_tx. The baud generator is
//   phase-restarted through o_br_rst at the start of every frame.
//
// Ports
//   i_clk      in   1          system clock, rising edge
//   i_rst      in   1          synchronous active-high reset
//   i_b_tick   in   1          one-cycle baud tick (OVERSAMPLE per bit)
//   o_br_rst   out  1          baud generator reset (high the cycle after accept)
//   i_tx_valid in   1          word available
//   i_tx_data  in   DATA_BITS  word to send
//   o_tx_ready out  1          controller can accept a word
//   o_tx       out  1          serial line, registered, idle high
//   o_busy     out  1          frame in progress
//   o_done     out  1          one-cycle pulse when a frame completes
//   o_state    out  3          current sequencer state (debug visibility)
//
// Handshake: a word transfers on any rising edge where i_tx_valid and
// o_tx_ready are both high. o_tx_ready is registered and depends on no input;
// the source may raise i_tx_valid at any time and must hold i_tx_data stable
// until the transfer edge. While the frame runs o_tx_ready stays low and
// i_tx_valid / i_tx_data are ignored.
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_b_tick,
    output logic                 o_br_rst,
    input  logic                 i_tx_valid,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done,
    output uart_state_t          o_state
);

    // Tick counter is sized so the stop phase can count two full bit periods
    // in one run instead of needing a separate stop-bit counter.
    localparam int CW = $clog2(OVERSAMPLE * 2);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_t          state_q, state_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic [BW-1:0]        bit_q, bit_n;
    logic [DATA_BITS-1:0] shreg_q, shreg_n;
    logic                 par_q, par_n;
    logic                 tx_q, tx_n;
    logic                 done_q, done_n;
    logic                 ready_q, ready_n;
    logic                 busy_q, busy_n;
    logic                 br_rst_q, br_rst_n;

    logic accept;
    logic bit_end;
    logic stop_end;

    assign accept   = i_tx_valid & ready_q;
    assign bit_end  = i_b_tick & (cnt_q == OS_LAST);
    assign stop_end = i_b_tick & (cnt_q == STOP_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            br_rst_q <= 1'b1;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            bit_q    <= bit_n;
            shreg_q  <= shreg_n;
            par_q    <= par_n;
            tx_q     <= tx_n;
            done_q   <= done_n;
            ready_q  <= ready_n;
            busy_q   <= busy_n;
            br_rst_q <= br_rst_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        bit_n    = bit_q;
        shreg_n  = shreg_q;
        par_n    = par_q;
        tx_n     = tx_q;
        done_n   = 1'b0;
        ready_n  = ready_q;
        busy_n   = busy_q;
        br_rst_n = 1'b0;

        case (state_q)
            IDLE: begin
                // Ticks are ignored here: the generator phase restarts on accept.
                tx_n = 1'b1;
                if (accept) begin
                    state_n  = START;
                    shreg_n  = i_tx_data;
                    // Parity is latched now, before the shift register is consumed.
                    par_n    = parity_f(MAX_DATA_BITS'(i_tx_data), PARITY_ODD != 0);
                    cnt_n    = '0;
                    bit_n    = '0;
                    tx_n     = 1'b0;
                    ready_n  = 1'b0;
                    busy_n   = 1'b1;
                    br_rst_n = 1'b1;
                end
            end

            START: begin
                if (i_b_tick) begin
                    if (bit_end) begin
                        cnt_n   = '0;
                        state_n = DATA;
                        tx_n    = shreg_q[0];
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
            end

            DATA: begin
                if (i_b_tick) begin
                    if (bit_end) begin
                        cnt_n = '0;
                        if (bit_q == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                state_n = PARITY;
                                tx_n    = par_q;
                            end else begin
                                state_n = STOP;
                                tx_n    = 1'b1;
                            end
                        end else begin
                            // Line takes the next bit as the register shifts.
                            bit_n   = bit_q + BW'(1);
                            shreg_n = shreg_q >> 1;
                            tx_n    = shreg_q[1];
                        end
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
            end

            PARITY: begin
                if (i_b_tick) begin
                    if (bit_end) begin
                        cnt_n   = '0;
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
            end

            STOP: begin
                tx_n = 1'b1;
                if (i_b_tick) begin
                    if (stop_end) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                        ready_n = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                bit_n   = '0;
                tx_n    = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign o_tx       = tx_q;
    assign o_done     = done_q;
    assign o_tx_ready = ready_q;
    assign o_busy     = busy_q;
    assign o_br_rst   = br_rst_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Four controller instances share clock, reset and baud tick:
//     dut0 defaults (8N1), dut1 even parity, dut2 odd parity, dut3 two stops.
//   A line decoder per instance rebuilds each frame from the tick-sampled
//   line and checks it against a scoreboard of words pushed when sent.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        valid [4];
    logic [7:0]  data  [4];
    logic        ready [4];
    logic        tx    [4];
    logic        busy  [4];
    logic        done  [4];
    logic        br_rst[4];
    uart_state_t st    [4];

    int pe_of[4] = '{0, 1, 1, 0};
    int sb_of[4] = '{1, 1, 1, 2};

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard entry: {dut[1:0], ticks[8:0], parity, data[7:0]}
    logic [19:0] exp_q[$];

    int   accepts   [4] = '{0, 0, 0, 0};
    int   frames_exp[4] = '{0, 0, 0, 0};
    int   done_cnt  [4] = '{0, 0, 0, 0};
    int   br_cnt    [4] = '{0, 0, 0, 0};
    int   n_t       [4] = '{0, 0, 0, 0};
    int   glitch    [4] = '{0, 0, 0, 0};
    bit   act       [4] = '{0, 0, 0, 0};
    logic prev_tx   [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic bits_r    [4][16];

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       exp_par;
        int         exp_ticks;
    } vec_t;
    vec_t vecs[12];

    // ---------------- DUTs ----------------
    uart_tx_ctrl u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_b_tick(tick), .o_br_rst(br_rst[0]),
        .i_tx_valid(valid[0]), .i_tx_data(data[0]), .o_tx_ready(ready[0]),
        .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]), .o_state(st[0])
    );
    uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_b_tick(tick), .o_br_rst(br_rst[1]),
        .i_tx_valid(valid[1]), .i_tx_data(data[1]), .o_tx_ready(ready[1]),
        .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]), .o_state(st[1])
    );
    uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_b_tick(tick), .o_br_rst(br_rst[2]),
        .i_tx_valid(valid[2]), .i_tx_data(data[2]), .o_tx_ready(ready[2]),
        .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]), .o_state(st[2])
    );
    uart_tx_ctrl #(.STOP_BITS(2)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_b_tick(tick), .o_br_rst(br_rst[3]),
        .i_tx_valid(valid[3]), .i_tx_data(data[3]), .o_tx_ready(ready[3]),
        .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]), .o_state(st[3])
    );

    // ---------------- clock / reset / tick ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int tc;
        tc   = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tc   = (tc + 1) % 4;
            tick = (tc == 0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check1(input string name, input int d, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %b want %b", name, d, got, want);
        end
    endtask

    task automatic checkn(input string name, input int d, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d (0x%0h) want %0d (0x%0h)", name, d, got, got, want, want);
        end
    endtask

    task automatic fail_now(input string name, input int d);
        n_cmp++;
        n_bad++;
        $display("FAIL %s dut%0d: event did not occur as required", name, d);
    endtask

    // ---------------- line decoder + scoreboard ----------------
    task automatic finish_frame(input int d);
        logic [19:0] it;
        logic [7:0]  dd;
        logic        pb;
        logic        stop_ok;
        int          base;
        act[d] = 0;
        for (int i = 0; i < 8; i++) dd[i] = bits_r[d][1 + i];
        base    = 9 + pe_of[d];
        pb      = bits_r[d][9];
        stop_ok = 1'b1;
        for (int j = 0; j < sb_of[d]; j++)
            if (bits_r[d][base + j] !== 1'b1) stop_ok = 1'b0;
        checkn("frame_glitch", d, glitch[d], 0);
        check1("stop_bits_high", d, stop_ok, 1'b1);
        check1("done_ready", d, ready[d], 1'b1);
        check1("done_busy", d, busy[d], 1'b0);
        checkn("done_state", d, int'(st[d]), int'(IDLE));
        if (exp_q.size() == 0) begin
            fail_now("unexpected_frame", d);
            return;
        end
        it = exp_q.pop_front();
        checkn("frame_dut", d, d, int'(it[19:18]));
        checkn("frame_ticks", d, n_t[d], int'(it[17:9]));
        checkn("frame_data", d, int'(dd), int'(it[7:0]));
        if (pe_of[d] != 0) check1("frame_parity", d, pb, it[8]);
    endtask

    task automatic decode_step(input int d);
        int k;
        if (rst) begin
            act[d]     = 0;
            prev_tx[d] = tx[d];
            return;
        end
        if (done[d])   done_cnt[d]++;
        if (br_rst[d]) br_cnt[d]++;
        if (tick) begin
            // The tick consumed at this edge belongs to the bit that was on
            // the line just before the edge.
            if (!act[d] && prev_tx[d] == 1'b0) begin
                act[d]    = 1;
                n_t[d]    = 0;
                glitch[d] = 0;
            end
            if (act[d]) begin
                k = n_t[d] / 16;
                if (k < 16) begin
                    if (n_t[d] % 16 == 0) bits_r[d][k] = prev_tx[d];
                    else if (bits_r[d][k] !== prev_tx[d]) glitch[d]++;
                end
                n_t[d]++;
            end
        end
        if (act[d] && done[d]) begin
            finish_frame(d);
        end else if (act[d] && n_t[d] > 200) begin
            fail_now("frame_overrun_no_done", d);
            act[d] = 0;
        end
        prev_tx[d] = tx[d];
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) decode_step(d);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int d, input logic [7:0] b, input bit track,
                        input logic par, input int tk);
        int guard;
        if (track) begin
            exp_q.push_back({2'(d), 9'(tk), par, b});
            frames_exp[d]++;
        end
        @(negedge clk);
        valid[d] = 1'b1;
        data[d]  = b;
        guard    = 0;
        while (!ready[d] && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!ready[d]) begin
            fail_now("ready_timeout", d);
            valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accepts[d]++;
        check1("accept_br_rst", d, br_rst[d], 1'b1);
        check1("accept_tx_low", d, tx[d], 1'b0);
        check1("accept_ready", d, ready[d], 1'b0);
        check1("accept_busy", d, busy[d], 1'b1);
        @(negedge clk);
        valid[d] = 1'b0;
        @(posedge clk);
        #1;
        check1("br_rst_one_cycle", d, br_rst[d], 1'b0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            fail_now("scoreboard_drain_timeout", 0);
            exp_q.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_ticks(input int nt);
        int c;
        c = 0;
        while (c < nt) begin
            @(posedge clk);
            #1;
            if (tick) c++;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int guard;
        int r;
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            valid[d] = 1'b0;
            data[d]  = 8'h00;
        end

        vecs[0] = '{0, 8'h55, 1'b0, 160};
        vecs[1] = '{1, 8'h07, 1'b1, 176};
        vecs[2] = '{2, 8'h07, 1'b0, 176};
        vecs[3] = '{3, 8'h5A, 1'b0, 176};
        vecs[4] = '{0, 8'h00, 1'b0, 160};
        vecs[5] = '{1, 8'hFF, 1'b0, 176};
        vecs[6] = '{2, 8'hFF, 1'b1, 176};
        vecs[7] = '{1, 8'h80, 1'b1, 176};
        vecs[8] = '{2, 8'h00, 1'b1, 176};
        for (int i = 9; i < 12; i++) begin
            r                 = $urandom_range(0, 3);
            vecs[i].dut       = r;
            vecs[i].data      = 8'($urandom_range(0, 255));
            vecs[i].exp_par   = (^vecs[i].data) ^ (r == 2);
            vecs[i].exp_ticks = (r == 0) ? 160 : 176;
        end

        // reset held for three edges
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                check1("rst_tx", d, tx[d], 1'b1);
                check1("rst_ready", d, ready[d], 1'b1);
                check1("rst_busy", d, busy[d], 1'b0);
                check1("rst_done", d, done[d], 1'b0);
                check1("rst_br_rst", d, br_rst[d], 1'b1);
                checkn("rst_state", d, int'(st[d]), int'(IDLE));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) check1("post_rst_br_rst", d, br_rst[d], 1'b0);

        // table of single frames across all configurations
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].dut, vecs[i].data, 1'b1, vecs[i].exp_par, vecs[i].exp_ticks);
            wait_idle();
        end

        // back-to-back with valid held high: second accept in the done cycle
        exp_q.push_back({2'd0, 9'd160, 1'b0, 8'hA5});
        exp_q.push_back({2'd0, 9'd160, 1'b0, 8'h3C});
        frames_exp[0] += 2;
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        @(posedge clk);
        #1;
        accepts[0]++;
        check1("b2b_first_accept", 0, busy[0], 1'b1);
        @(negedge clk);
        data[0] = 8'h3C;
        guard   = 0;
        while (!done[0] && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!done[0]) begin
            fail_now("b2b_done_timeout", 0);
        end else begin
            check1("b2b_done_cycle_tx_high", 0, tx[0], 1'b1);
            @(posedge clk);
            #1;
            accepts[0]++;
            check1("b2b_second_accept_br_rst", 0, br_rst[0], 1'b1);
            check1("b2b_start_low", 0, tx[0], 1'b0);
            check1("b2b_ready_low", 0, ready[0], 1'b0);
        end
        @(negedge clk);
        valid[0] = 1'b0;
        wait_idle();

        // reset in the middle of data bit 3 of 0xF0: frame aborted, no done
        send(0, 8'hF0, 1'b0, 1'b0, 160);
        wait_ticks(72);
        checkn("midrst_in_data", 0, int'(st[0]), int'(DATA));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check1("midrst_tx_high", 0, tx[0], 1'b1);
        check1("midrst_no_done", 0, done[0], 1'b0);
        check1("midrst_ready", 0, ready[0], 1'b1);
        checkn("midrst_state", 0, int'(st[0]), int'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        send(0, 8'h81, 1'b1, 1'b0, 160);
        wait_idle();

        // two stop bits; a mid-frame valid pulse with 0xFF must be ignored
        send(3, 8'hC3, 1'b1, 1'b0, 176);
        wait_ticks(40);
        @(negedge clk);
        valid[3] = 1'b1;
        data[3]  = 8'hFF;
        @(posedge clk);
        #1;
        check1("ignore_ready_low", 3, ready[3], 1'b0);
        check1("ignore_busy", 3, busy[3], 1'b1);
        check1("ignore_no_br_rst", 3, br_rst[3], 1'b0);
        @(negedge clk);
        valid[3] = 1'b0;
        wait_idle();

        // end-of-run totals
        for (int d = 0; d < 4; d++) begin
            checkn("done_pulse_count", d, done_cnt[d], frames_exp[d]);
            checkn("br_rst_pulse_count", d, br_cnt[d], accepts[d]);
        end
        checkn("scoreboard_empty", 0, exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
